// File: rtl/top.sv
// SPI-programmable 16-bit PWM timer.
//
// Ports:
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   sclk    in  SPI clock (mode 0, shifting is clocked directly by sclk)
//   cs_n    in  SPI chip select, active low; high clears the frame state
//   mosi    in  SPI serial data in, MSB first
//   miso    out SPI serial data out, driven only during a read data phase
//   pwm_out out registered PWM output
//
// Frame: 16 bits, command byte {wr, x, addr[5:0]} followed by a data byte.
// Writes cross into the clk domain via a toggle flag and 2-flop synchronizer.
module top (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic miso,
    output logic pwm_out
);

    // ---------------- SPI (sclk domain) ----------------
    logic       w_spi_rst_n;
    logic [4:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic       r_cmd_wr;
    logic [5:0] r_cmd_addr;
    logic [7:0] r_rd_data;
    logic [5:0] w_rd_addr;
    logic [7:0] w_rd_val;
    logic       r_miso;
    logic       r_wr_tog;
    logic [5:0] r_wr_addr;
    logic [7:0] r_wr_data;

    // Frame state is cleared by either the system reset or cs_n going high.
    assign w_spi_rst_n = rst_n & ~cs_n;
    // Address is complete on the 8th rising edge: 5 bits already shifted plus mosi.
    assign w_rd_addr   = {r_shift[4:0], mosi};

    always_ff @(posedge sclk or negedge w_spi_rst_n) begin
        if (!w_spi_rst_n) begin
            r_bit_cnt  <= 5'd0;
            r_shift    <= 7'd0;
            r_cmd_wr   <= 1'b0;
            r_cmd_addr <= 6'd0;
            r_rd_data  <= 8'd0;
        end else begin
            r_shift <= {r_shift[5:0], mosi};
            // Saturate so extra clocks in an over-long frame cannot re-trigger.
            if (r_bit_cnt != 5'd16) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            if (r_bit_cnt == 5'd7) begin
                r_cmd_wr   <= r_shift[6];
                r_cmd_addr <= w_rd_addr;
                r_rd_data  <= w_rd_val;
            end
        end
    end

    // Write handoff survives cs_n so the toggle never flips spuriously.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_tog  <= 1'b0;
            r_wr_addr <= 6'd0;
            r_wr_data <= 8'd0;
        end else if (r_bit_cnt == 5'd15 && r_cmd_wr) begin
            r_wr_addr <= r_cmd_addr;
            r_wr_data <= {r_shift, mosi};
            r_wr_tog  <= ~r_wr_tog;
        end
    end

    // Bit counts 8..15 are the data phase; ~cnt[2:0] selects bit 7 down to 0.
    always_ff @(negedge sclk or negedge w_spi_rst_n) begin
        if (!w_spi_rst_n) begin
            r_miso <= 1'b0;
        end else if (!r_cmd_wr && r_bit_cnt[4:3] == 2'b01) begin
            r_miso <= r_rd_data[~r_bit_cnt[2:0]];
        end else begin
            r_miso <= 1'b0;
        end
    end

    assign miso = r_miso;

    // ---------------- Register file (clk domain) ----------------
    logic        r_tog_s1;
    logic        r_tog_s2;
    logic        r_tog_s3;
    logic        w_wr_stb;
    logic [15:0] r_period;
    logic        r_cnt_en;
    logic [15:0] r_cmp1;
    logic [15:0] r_cmp2;
    logic        r_cnt_rst;
    logic [7:0]  r_prescale;
    logic        r_updown;
    logic        r_pwm_en;
    logic [1:0]  r_func;
    logic [15:0] r_count;
    logic [7:0]  r_presc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tog_s1 <= 1'b0;
            r_tog_s2 <= 1'b0;
            r_tog_s3 <= 1'b0;
        end else begin
            r_tog_s1 <= r_wr_tog;
            r_tog_s2 <= r_tog_s1;
            r_tog_s3 <= r_tog_s2;
        end
    end

    assign w_wr_stb = r_tog_s2 ^ r_tog_s3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_period   <= 16'd0;
            r_cnt_en   <= 1'b0;
            r_cmp1     <= 16'd0;
            r_cmp2     <= 16'd0;
            r_cnt_rst  <= 1'b0;
            r_prescale <= 8'd0;
            r_updown   <= 1'b1;
            r_pwm_en   <= 1'b0;
            r_func     <= 2'd0;
        end else if (w_wr_stb) begin
            case (r_wr_addr)
                6'h00:   r_period[7:0]  <= r_wr_data;
                6'h01:   r_period[15:8] <= r_wr_data;
                6'h02:   r_cnt_en       <= r_wr_data[0];
                6'h03:   r_cmp1[7:0]    <= r_wr_data;
                6'h04:   r_cmp1[15:8]   <= r_wr_data;
                6'h05:   r_cmp2[7:0]    <= r_wr_data;
                6'h06:   r_cmp2[15:8]   <= r_wr_data;
                6'h07:   r_cnt_rst      <= r_wr_data[0];
                6'h0A:   r_prescale     <= r_wr_data;
                6'h0B:   r_updown       <= r_wr_data[0];
                6'h0C:   r_pwm_en       <= r_wr_data[0];
                6'h0D:   r_func         <= r_wr_data[1:0];
                default: ;
            endcase
        end
    end

    // Sampled from the sclk domain at the 8th edge.
    always_comb begin
        w_rd_val = 8'h00;
        case (w_rd_addr)
            6'h00:   w_rd_val = r_period[7:0];
            6'h01:   w_rd_val = r_period[15:8];
            6'h02:   w_rd_val = {7'd0, r_cnt_en};
            6'h03:   w_rd_val = r_cmp1[7:0];
            6'h04:   w_rd_val = r_cmp1[15:8];
            6'h05:   w_rd_val = r_cmp2[7:0];
            6'h06:   w_rd_val = r_cmp2[15:8];
            6'h07:   w_rd_val = {7'd0, r_cnt_rst};
            6'h08:   w_rd_val = r_count[7:0];
            6'h09:   w_rd_val = r_count[15:8];
            6'h0A:   w_rd_val = r_prescale;
            6'h0B:   w_rd_val = {7'd0, r_updown};
            6'h0C:   w_rd_val = {7'd0, r_pwm_en};
            6'h0D:   w_rd_val = {6'd0, r_func};
            default: w_rd_val = 8'h00;
        endcase
    end

    // ---------------- Counter and PWM ----------------
    logic [15:0] w_step_val;
    logic        w_mode_ok;
    logic        r_pwm;

    always_comb begin
        w_step_val = r_count;
        if (r_updown) begin
            w_step_val = (r_count >= r_period) ? 16'd0 : r_count + 16'd1;
        end else if (r_count > r_period || r_count == 16'd0) begin
            w_step_val = r_period;
        end else begin
            w_step_val = r_count - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= 16'd0;
            r_presc_cnt <= 8'd0;
        end else if (r_cnt_rst) begin
            r_count     <= 16'd0;
            r_presc_cnt <= 8'd0;
        end else if (r_cnt_en) begin
            if (r_presc_cnt >= r_prescale) begin
                r_presc_cnt <= 8'd0;
                r_count     <= w_step_val;
            end else begin
                r_presc_cnt <= r_presc_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_mode_ok = 1'b0;
        case (r_func)
            2'b00:   w_mode_ok = (r_cmp1 != 16'd0) && (r_count <= r_cmp1);
            2'b01:   w_mode_ok = (r_count >= r_cmp1);
            default: w_mode_ok = (r_count >= r_cmp1) && (r_count < r_cmp2);
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= r_pwm_en && (r_cmp1 != r_cmp2) && w_mode_ok;
        end
    end

    assign pwm_out = r_pwm;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the SPI PWM timer: stimulus pushes expected ranges,
// monitors pop them when a read frame completes or a PWM window closes.
module tb_top;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso;
    logic pwm_out;

    int n_checks = 0;
    int n_errors = 0;

    string sb_name[$];
    int    sb_lo[$];
    int    sb_hi[$];

    int win_len  = 0;
    bit win_done = 1'b0;

    top dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sclk    (sclk),
        .cs_n    (cs_n),
        .mosi    (mosi),
        .miso    (miso),
        .pwm_out (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic sb_push(input string name, input int lo, input int hi);
        sb_name.push_back(name);
        sb_lo.push_back(lo);
        sb_hi.push_back(hi);
    endtask

    task automatic sb_pop_check(input string src, input int act);
        string nm;
        int    lo;
        int    hi;
        if (sb_name.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: unexpected output %0d, scoreboard empty", src, act);
        end else begin
            nm = sb_name.pop_front();
            lo = sb_lo.pop_front();
            hi = sb_hi.pop_front();
            check(nm, act, lo, hi);
        end
    endtask

    // SPI monitor: decodes frames from the pins, compares completed reads.
    int         mon_bits = 0;
    logic [7:0] mon_cmd  = 8'd0;
    logic [7:0] mon_rx   = 8'd0;

    initial begin
        forever begin
            @(posedge sclk or posedge cs_n);
            if (cs_n) begin
                if (mon_bits == 16 && !mon_cmd[7]) begin
                    sb_pop_check("spi_read", int'(mon_rx));
                end
                mon_bits = 0;
                mon_rx   = 8'd0;
            end else begin
                if (mon_bits < 8) mon_cmd = {mon_cmd[6:0], mosi};
                else              mon_rx  = {mon_rx[6:0], miso};
                mon_bits++;
            end
        end
    end

    // PWM monitor: counts high cycles over a requested window.
    int hc;
    initial begin
        forever begin
            @(negedge clk);
            if (win_len > 0) begin
                hc = 0;
                for (int i = 0; i < win_len; i++) begin
                    if (pwm_out) hc++;
                    @(negedge clk);
                end
                sb_pop_check("pwm_window", hc);
                win_len  = 0;
                win_done = 1'b1;
            end
        end
    end

    // sclk edges land on clk falling edges, clear of the rising edge.
    task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] data, input int nbits);
        logic [15:0] frame;
        frame = {cmd, data};
        @(negedge clk);
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = frame[15-i];
            #10 sclk = 1'b1;
            #10 sclk = 1'b0;
        end
        #10;
        mosi = 1'b0;
        cs_n = 1'b1;
        #20;
    endtask

    task automatic spi_write(input logic [5:0] addr, input logic [7:0] data);
        spi_xfer({2'b10, addr}, data, 16);
        repeat (6) @(posedge clk);
    endtask

    task automatic spi_read(input logic [5:0] addr, input int lo, input int hi, input string name);
        sb_push(name, lo, hi);
        spi_xfer({2'b00, addr}, 8'h00, 16);
    endtask

    task automatic measure(input int n, input int lo, input int hi, input string name);
        sb_push(name, lo, hi);
        win_done = 1'b0;
        win_len  = n;
        for (int i = 0; i < n + 10 && !win_done; i++) @(posedge clk);
        if (!win_done) begin
            check({name, "_timeout"}, 0, 1, 1);
        end
    endtask

    initial begin
        #2;
        check("reset_pwm_out", int'(pwm_out), 0, 0);
        check("reset_miso", int'(miso), 0, 0);
        #21 rst_n = 1'b1;
        repeat (3) @(posedge clk);

        // Reset values and unmapped read
        spi_read(6'h00, 0, 0, "rst_period_lo");
        spi_read(6'h0B, 1, 1, "rst_updown");
        spi_read(6'h0D, 0, 0, "rst_functions");
        spi_read(6'h02, 0, 0, "rst_counter_en");
        spi_read(6'h20, 0, 0, "unmapped_read");

        // Aborted frame must not write
        spi_xfer({2'b10, 6'h0A}, 8'h55, 12);
        repeat (6) @(posedge clk);
        spi_read(6'h0A, 0, 0, "aborted_write");

        // Left-aligned setup, counter held in reset
        spi_write(6'h07, 8'h01);
        spi_write(6'h00, 8'h07);
        spi_write(6'h01, 8'h00);
        spi_write(6'h0A, 8'h00);
        spi_write(6'h03, 8'h03);
        spi_write(6'h02, 8'h01);
        spi_write(6'h0C, 8'hFF);
        spi_write(6'h0D, 8'h00);
        spi_write(6'h08, 8'h55);
        spi_read(6'h08, 0, 0, "readonly_ignored");
        spi_read(6'h00, 7, 7, "readback_period");
        spi_read(6'h03, 3, 3, "readback_cmp1");
        spi_read(6'h0D, 0, 0, "readback_func_left");
        spi_read(6'h0C, 1, 1, "pwm_en_unused_bits");

        spi_write(6'h07, 8'h00);
        measure(40, 19, 21, "left_c1_3");
        spi_read(6'h08, 0, 7, "count_lo_running");
        spi_read(6'h09, 0, 0, "count_hi_running");

        // Range 2..5
        spi_write(6'h03, 8'h02);
        spi_write(6'h05, 8'h06);
        spi_write(6'h0D, 8'hFE);
        spi_read(6'h0D, 2, 2, "readback_func_range");
        measure(40, 19, 21, "range_2_6");

        // Right-aligned, then the same in down mode
        spi_write(6'h03, 8'h05);
        spi_write(6'h0D, 8'h01);
        measure(40, 14, 16, "right_c1_5");
        spi_write(6'h0B, 8'h00);
        spi_read(6'h0B, 0, 0, "readback_down");
        measure(40, 14, 16, "right_c1_5_down");
        spi_write(6'h0B, 8'h01);

        // Equal compares force low
        spi_write(6'h02, 8'h00);
        spi_write(6'h05, 8'h05);
        spi_write(6'h02, 8'h01);
        measure(16, 0, 1, "equal_compares");

        // Left with COMPARE1=0 is always low
        spi_write(6'h03, 8'h00);
        spi_write(6'h0D, 8'h00);
        measure(24, 0, 1, "left_c1_0");

        // Prescale 1 doubles each count's duration
        spi_write(6'h03, 8'h03);
        spi_write(6'h0A, 8'h01);
        measure(80, 39, 41, "left_prescale_1");

        repeat (5) @(posedge clk);
        if (sb_name.size() != 0) begin
            check("scoreboard_drained", sb_name.size(), 0, 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
